// File: rtl/wght_pkg.sv
// Shared constants for the weight-update unit: fixed-point format, FSM encoding,
// and saturation limits of the default weight word.
package wght_pkg;

  localparam int unsigned FRAC  = 24;
  localparam int unsigned WGT_W = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;
  localparam logic [1:0] CLR   = 2'd3;

  localparam logic [WGT_W-1:0] SAT_MAX = {1'b0, {(WGT_W-1){1'b1}}};
  localparam logic [WGT_W-1:0] SAT_MIN = {1'b1, {(WGT_W-1){1'b0}}};

endpackage

// File: rtl/wght_upd_sat_sub.sv
// Signed saturating subtract: o_diff_c = sat(i_a - i_b), computed one bit wider
// and clamped to the representable WIDTH-bit range.
module sat_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff_c
);

  logic [WIDTH:0] w_full;

  assign w_full = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};

  // Overflow shows up as disagreement between the two top bits.
  always_comb begin
    o_diff_c = w_full[WIDTH-1:0];
    if (w_full[WIDTH] != w_full[WIDTH-1]) begin
      o_diff_c = w_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/wght_upd.sv
// Weight bank with end-of-batch update: counts samples, then walks every
// accumulator, subtracts delta/BATCH with saturation and clears the accumulators.
module wght_upd
  import wght_pkg::*;
#(
  parameter int unsigned WIDTH      = WGT_W,
  parameter int unsigned NW         = 4,
  parameter int unsigned LOG2_BATCH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_smp,
  input  logic                  i_init_en,
  input  logic [$clog2(NW)-1:0] i_init_addr,
  input  logic [WIDTH-1:0]      i_init_data,
  input  logic [$clog2(NW)-1:0] i_w_addr,
  output logic [WIDTH-1:0]      o_w,
  output logic                  o_rd_en,
  output logic [$clog2(NW)-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]      i_rd_data,
  output logic                  o_acc_clr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ovr
);

  localparam int unsigned AW = $clog2(NW);
  localparam int unsigned CW = LOG2_BATCH;

  logic [1:0]       r_state, w_state_nxt;
  logic [AW-1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_w [NW];
  logic [WIDTH-1:0] w_delta, w_new;
  logic             r_rd_en, r_clr, r_busy, r_ovr;
  logic [AW-1:0]    r_rd_addr;

  assign w_delta = WIDTH'($signed(i_rd_data) >>> LOG2_BATCH);

  sat_sub #(.WIDTH(WIDTH)) u_sat (
    .i_a      (r_w[r_idx]),
    .i_b      (w_delta),
    .o_diff_c (w_new)
  );

  // Next-state, index and sample-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_smp) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == {CW{1'b1}}) begin
            w_idx_nxt   = '0;
            w_state_nxt = FETCH;
          end
        end
      end
      FETCH: w_state_nxt = APPLY;
      APPLY: begin
        if (r_idx == AW'(NW - 1)) begin
          w_state_nxt = CLR;
        end else begin
          w_idx_nxt   = r_idx + AW'(1);
          w_state_nxt = FETCH;
        end
      end
      CLR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered off the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_clr     <= 1'b0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_en   <= (w_state_nxt == FETCH);
      r_rd_addr <= w_idx_nxt;
      r_clr     <= (w_state_nxt == CLR);
      r_busy    <= (w_state_nxt != IDLE);
      r_ovr     <= r_ovr | (i_smp && (r_state != IDLE));
    end
  end

  // Weight bank: preload only while idle, update one entry per APPLY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) r_w[i] <= '0;
    end else if ((r_state == IDLE) && i_init_en) begin
      r_w[i_init_addr] <= i_init_data;
    end else if (r_state == APPLY) begin
      r_w[r_idx] <= w_new;
    end
  end

  assign o_w       = r_w[i_w_addr];
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_acc_clr = r_clr;
  assign o_done    = r_clr;
  assign o_busy    = r_busy;
  assign o_ovr     = r_ovr;

endmodule

// File: tb/tb_wght_upd.sv
// Scoreboard bench for wght_upd: stimulus pushes expectations from an arithmetic
// reference model, a monitor pops and compares them as the DUT reports.
module tb_wght_upd;
  import wght_pkg::*;

  localparam int unsigned W     = 32;
  localparam int unsigned N     = 4;
  localparam int unsigned LB    = 2;
  localparam int unsigned AW    = 2;
  localparam int          BATCH = 1 << LB;

  typedef struct packed { logic [N-1:0][W-1:0] w; int due; } done_t;
  typedef struct packed {
    logic [N-1:0][W-1:0] w; logic busy; logic ovr; logic full; logic wchk;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_smp = 1'b0, i_init_en = 1'b0;
  logic [AW-1:0] i_init_addr = '0, i_w_addr = '0;
  logic [W-1:0]  i_init_data = '0, i_rd_data = '0, o_w;
  logic          o_rd_en, o_acc_clr, o_busy, o_done, o_ovr;
  logic [AW-1:0] o_rd_addr;

  logic [W-1:0] acc [N];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  done_t        done_q[$];
  snap_t        snap_q[$];

  logic [W-1:0] m_w [N];
  int           m_cnt = 0;
  bit           m_ovr = 1'b0;
  int           m_bs = -100;
  int           m_be = -100;

  wght_upd #(.WIDTH(W), .NW(N), .LOG2_BATCH(LB)) dut (
    .clk(clk), .rst(rst), .i_smp(i_smp), .i_init_en(i_init_en),
    .i_init_addr(i_init_addr), .i_init_data(i_init_data), .i_w_addr(i_w_addr),
    .o_w(o_w), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_acc_clr(o_acc_clr), .o_busy(o_busy), .o_done(o_done), .o_ovr(o_ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Accumulator bank: answers a read one cycle after the request.
  always @(posedge clk) if (o_rd_en) i_rd_data <= acc[o_rd_addr];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: w - floor(a / BATCH), clamped to the signed word range.
  function automatic logic [W-1:0] upd(logic [W-1:0] w, logic [W-1:0] a);
    longint sw, sa, q, r;
    sw = longint'($signed(w));
    sa = longint'($signed(a));
    q  = sa / BATCH;
    if (sa < 0 && q * BATCH != sa) q = q - 1;
    r = sw - q;
    if (r > longint'($signed(SAT_MAX))) r = longint'($signed(SAT_MAX));
    if (r < longint'($signed(SAT_MIN))) r = longint'($signed(SAT_MIN));
    return W'(r);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
      default: return W'($urandom());
    endcase
  endfunction

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic read_all(output logic [N-1:0][W-1:0] v);
    for (int k = 0; k < N; k++) begin
      i_w_addr = AW'(k);
      #1;
      v[k] = o_w;
    end
  endtask

  initial begin : monitor
    int                  rd_k;
    logic [N-1:0][W-1:0] v;
    done_t               e;
    snap_t               s;
    logic                rd_en, clr, done, busy, ovr;
    logic [AW-1:0]       rd_addr;
    rd_k = 0;
    forever begin
      @(negedge clk);
      rd_en = o_rd_en; clr = o_acc_clr; done = o_done; busy = o_busy;
      ovr = o_ovr; rd_addr = o_rd_addr;
      if (!rst) begin
        rd_k = 0;
      end else begin
        if (snap_q.size() != 0) begin
          s = snap_q.pop_front();
          chk("busy", W'(busy), W'(s.busy));
          chk("ovr", W'(ovr), W'(s.ovr));
          if (s.full) begin
            chk("rd_en_idle", W'(rd_en), '0);
            chk("done_idle", W'(done), '0);
            chk("acc_clr_idle", W'(clr), '0);
            chk("rd_addr_reset", W'(rd_addr), '0);
          end
          if (s.wchk) begin
            read_all(v);
            for (int k = 0; k < N; k++) chk($sformatf("w%0d", k), v[k], s.w[k]);
          end
        end
        if (rd_en) begin
          chk("rd_addr_seq", W'(rd_addr), W'(rd_k));
          rd_k = (rd_k + 1) % N;
        end
        if (done || clr) begin
          if (done_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done: got done=%0b clr=%0b expected no pulse (cycle %0d)",
                     done, clr, cyc);
          end else begin
            e = done_q.pop_front();
            chk("done_cycle", W'(cyc), W'(e.due));
            chk("done", W'(done), W'(1));
            chk("acc_clr", W'(clr), W'(1));
            chk("fetch_count", W'(rd_k), '0);
            read_all(v);
            for (int k = 0; k < N; k++) chk($sformatf("w%0d_upd", k), v[k], e.w[k]);
          end
        end
        if (done_q.size() != 0 && cyc > done_q[0].due) begin
          checks++; failures++;
          $display("FAIL done_timeout: got no done by cycle %0d expected at %0d", cyc, done_q[0].due);
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit smp, bit ien, int addr, logic [W-1:0] d);
    done_t e;
    i_smp = smp; i_init_en = ien; i_init_addr = AW'(addr); i_init_data = d;
    if (cyc > m_be) begin
      if (ien) m_w[addr] = d;
      if (smp) begin
        m_cnt++;
        if (m_cnt == BATCH) begin
          m_cnt = 0;
          for (int k = 0; k < N; k++) begin
            m_w[k] = upd(m_w[k], acc[k]);
            e.w[k] = m_w[k];
          end
          e.due = cyc + 2 * N + 1;
          done_q.push_back(e);
          m_bs = cyc + 1;
          m_be = cyc + 2 * N + 1;
        end
      end
    end else if (smp) begin
      m_ovr = 1'b1;
    end
    step();
    i_smp = 1'b0; i_init_en = 1'b0;
  endtask

  task automatic snap(bit full, bit wchk);
    snap_t s;
    for (int k = 0; k < N; k++) s.w[k] = m_w[k];
    s.busy = (cyc >= m_bs && cyc <= m_be);
    s.ovr = m_ovr; s.full = full; s.wchk = wchk;
    snap_q.push_back(s);
    step();
  endtask

  task automatic wait_idle();
    while (cyc <= m_be) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    for (int k = 0; k < N; k++) m_w[k] = '0;
    m_cnt = 0; m_ovr = 1'b0; m_bs = -100; m_be = -100;
    done_q.delete();
  endtask

  task automatic batch(bit rnd);
    for (int s = 0; s < BATCH; s++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) step();
        drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), W'($urandom()));
      end else begin
        drive(1'b1, 1'b0, 0, '0);
      end
    end
    wait_idle();
    snap(1'b0, 1'b1);
  endtask

  initial begin : stim
    for (int k = 0; k < N; k++) acc[k] = '0;
    do_reset();
    snap(1'b1, 1'b1);
    // Three samples stay idle, the fourth starts the update.
    for (int k = 0; k < N; k++) acc[k] = W'($urandom());
    for (int s = 0; s < BATCH - 1; s++) drive(1'b1, 1'b0, 0, '0);
    snap(1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, '0);
    snap(1'b0, 1'b0);
    wait_idle();
    snap(1'b0, 1'b1);
    // 1.0 minus 2.0/4, other weights untouched.
    drive(1'b0, 1'b1, 0, W'(1) << FRAC);
    for (int k = 1; k < N; k++) drive(1'b0, 1'b1, k, W'($urandom()));
    acc[0] = W'(2) << FRAC;
    for (int k = 1; k < N; k++) acc[k] = '0;
    batch(1'b0);
    // Floored negative delta and both saturation directions.
    drive(1'b0, 1'b1, 1, 32'h0000_0000);
    drive(1'b0, 1'b1, 2, 32'h7FFF_FF00);
    drive(1'b0, 1'b1, 3, 32'h8000_0100);
    acc[0] = '0; acc[1] = 32'hFFFF_FFFD; acc[2] = 32'h8000_0000; acc[3] = 32'h7FFF_FFFC;
    batch(1'b0);
    repeat (6) begin
      for (int k = 0; k < N; k++) begin
        acc[k] = pick();
        if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b1, k, pick());
      end
      batch(1'b1);
    end
    // Sample and preload while busy are dropped; overrun flag sticks.
    for (int k = 0; k < N; k++) acc[k] = pick();
    for (int s = 0; s < BATCH; s++) drive(1'b1, 1'b0, 0, '0);
    drive(1'b1, 1'b1, 0, 32'hDEAD_BEEF);
    wait_idle();
    snap(1'b0, 1'b1);
    for (int s = 0; s < BATCH - 1; s++) drive(1'b1, 1'b0, 0, '0);
    snap(1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, '0);
    wait_idle();
    snap(1'b0, 1'b1);
    // Reset in the middle of an update aborts it without a clear.
    for (int k = 0; k < N; k++) acc[k] = pick();
    for (int s = 0; s < BATCH; s++) drive(1'b1, 1'b0, 0, '0);
    step(); step(); step();
    do_reset();
    snap(1'b1, 1'b1);
    for (int k = 0; k < N; k++) drive(1'b0, 1'b1, k, pick());
    batch(1'b1);
    repeat (12) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wght_upd.md
# wght_upd

Weight update unit: the consumer side of the per-weight gradient accumulators. Counts training samples. At the end of each mini-batch it reads every accumulated delta (Σ d·a·lr), scales it by 1/BATCH, subtracts it from the stored weight with saturation, then pulses a clear to the accumulators. It holds the layer's weight bank and serves it to the forward datapath.

## Interface

Parameters:
- WIDTH, 32, signed fixed-point word width (Q8.24, FRAC=24).
- NW, 4, number of weights in the bank (≥2).
- LOG2_BATCH, 2, batch size = 2^LOG2_BATCH samples.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous, active-low reset.
- i_smp, in, 1, one-cycle pulse per completed sample accumulation.
- i_init_en, in, 1, weight preload strobe.
- i_init_addr, in, clog2(NW), preload index.
- i_init_data, in, WIDTH, preload value.
- i_w_addr, in, clog2(NW), forward-path weight select.
- o_w, out, WIDTH, weight[i_w_addr], combinational read.
- o_rd_en, out, 1, accumulator read request.
- o_rd_addr, out, clog2(NW), accumulator index being read.
- i_rd_data, in, WIDTH, accumulator value, valid the cycle after o_rd_en.
- o_acc_clr, out, 1, one-cycle clear to all accumulators.
- o_busy, out, 1, update in progress (state ≠ IDLE).
- o_done, out, 1, one-cycle pulse when the batch update finishes.
- o_ovr, out, 1, sticky flag: i_smp arrived while busy.

## Operation

- States are IDLE, FETCH, APPLY and CLR.
- IDLE:
  - i_smp increments the sample counter cnt (LOG2_BATCH bits, wraps).
  - If i_smp arrives while cnt == 2^LOG2_BATCH−1, cnt wraps to 0, idx is set to 0 and the FSM moves to FETCH.
  - i_init_en writes weight[i_init_addr] <= i_init_data.
  - If i_init_en and i_smp arrive in the same cycle, both take effect.
- FETCH: drive o_rd_en=1 and o_rd_addr=idx, then go to APPLY.
- APPLY:
  - weight[idx] <= sat(weight[idx] − (i_rd_data >>> LOG2_BATCH)). The shift is arithmetic and floors toward −∞.
  - The subtraction is computed in WIDTH+1 bits and then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - If idx == NW−1, go to CLR. Otherwise increment idx and go to FETCH.
- CLR: drive o_acc_clr=1 and o_done=1 for one cycle, then return to IDLE.
- Outside IDLE:
  - i_smp is ignored and not counted, and sets o_ovr. o_ovr is cleared only by reset.
  - i_init_en is ignored.
- o_w is always readable. During APPLY it shows the old value; the new value is visible from the next cycle.
- Reset:
  - All weights, cnt, idx and o_ovr go to 0. The state goes to IDLE.
  - o_rd_en, o_acc_clr, o_done and o_busy are 0. o_rd_addr is 0.
  - Reset in the middle of an update aborts it. Weights already written are also zeroed, and no o_acc_clr is issued.

## Timing

- Trigger at cycle T (i_smp sampled with cnt at its maximum).
  - Weight k: FETCH at T+1+2k, APPLY at T+2+2k.
  - CLR at T+2·NW+1.
  - IDLE again at T+2·NW+2.
- Update latency is 2·NW+1 cycles after the trigger edge. With NW=4, CLR falls at T+9.
- o_busy is high from T+1 through T+2·NW+1 inclusive.
- The accumulator must present i_rd_data exactly one cycle after o_rd_en. No wait states are supported.
- The accumulator must not accumulate between the trigger and o_acc_clr. Upstream guarantees this by holding off while o_busy is high.

## Structure

- Shared package wght_pkg holds:
  - FRAC=24.
  - The state encoding: IDLE=2'd0, FETCH=2'd1, APPLY=2'd2, CLR=2'd3.
  - Saturation limit constants derived from WIDTH.
- One sub-module, sat_sub: WIDTH-parameterised signed saturating a−b. It is combinational and instantiated once in APPLY.
- The weight bank is an NW×WIDTH register array inside wght_upd.

## Test plan

Defaults WIDTH=32, NW=4, LOG2_BATCH=2, with a one-cycle-latency accumulator model.

1. Reset → all outputs 0, o_w=0 for every address. Three i_smp pulses → o_busy stays 0. Fourth pulse → o_busy=1 the next cycle and o_rd_addr sequence 0,1,2,3, with o_acc_clr and o_done at T+9.
2. Preload w0=0x0100_0000 (1.0), acc0=0x0200_0000, others 0, then 4 samples → w0=0x0080_0000 (0.5) and w1..w3 unchanged.
3. Negative delta: w1=0, acc1=0xFFFF_FFFD, 4 samples → w1=0x0000_0001 (floored shift gives −1).
4. Saturation: w2=0x7FFF_FF00, acc2=0x8000_0000 → w2=0x7FFF_FFFF. Separately, w3=0x8000_0100, acc3=0x7FFF_FFFC → w3=0x8000_0000.
5. i_smp and i_init_en pulsed during o_busy → o_ovr=1, the weight is unaffected by the init write, and the next update still fires after exactly 4 further samples.
6. Reset asserted at T+4 (mid-update) → state IDLE, all weights 0, no o_acc_clr pulse. The next batch completes normally.
